// File: rtl/reset_sequencer.sv
// Reset sequencer: holds memory, register-file and processor resets after power-on
// or soft restart, then releases them in a fixed order aligned to a processor-clock falling edge.
module reset_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int STAGE_GAP   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       soft_rst_req,
  input  logic       proc_clk_level,
  output logic       imem_rst,
  output logic       dmem_rst,
  output logic       regfile_rst,
  output logic       proc_rst,
  output logic       seq_done,
  output logic [7:0] release_count
);

  typedef enum logic [2:0] {
    HOLD,
    WAIT_EDGE,
    REL_MEM,
    REL_RF,
    RUN
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(STAGE_GAP - 1);

  // Completed-sequence counter sticks at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       prev_lvl_q, prev_lvl_d;
  logic       imem_rst_q, imem_rst_d;
  logic       dmem_rst_q, dmem_rst_d;
  logic       regfile_rst_q, regfile_rst_d;
  logic       proc_rst_q, proc_rst_d;
  logic       seq_done_q, seq_done_d;
  logic [7:0] release_count_q, release_count_d;
  logic       fall_edge;

  assign fall_edge = prev_lvl_q & ~proc_clk_level;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    prev_lvl_d      = proc_clk_level;
    imem_rst_d      = imem_rst_q;
    dmem_rst_d      = dmem_rst_q;
    regfile_rst_d   = regfile_rst_q;
    proc_rst_d      = proc_rst_q;
    seq_done_d      = seq_done_q;
    release_count_d = release_count_q;

    // A restart request beats any pending release, including a coincident falling edge.
    if (soft_rst_req) begin
      state_d       = HOLD;
      cnt_d         = 8'd0;
      imem_rst_d    = 1'b1;
      dmem_rst_d    = 1'b1;
      regfile_rst_d = 1'b1;
      proc_rst_d    = 1'b1;
      seq_done_d    = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = WAIT_EDGE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        WAIT_EDGE: begin
          if (fall_edge) begin
            state_d    = REL_MEM;
            cnt_d      = 8'd0;
            imem_rst_d = 1'b0;
            dmem_rst_d = 1'b0;
          end
        end
        REL_MEM: begin
          if (cnt_q == GAP_LAST) begin
            state_d       = REL_RF;
            cnt_d         = 8'd0;
            regfile_rst_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        REL_RF: begin
          if (cnt_q == GAP_LAST) begin
            state_d         = RUN;
            cnt_d           = 8'd0;
            proc_rst_d      = 1'b0;
            seq_done_d      = 1'b1;
            release_count_d = sat_inc(release_count_q);
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = HOLD;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= HOLD;
      cnt_q           <= 8'd0;
      prev_lvl_q      <= 1'b0;
      imem_rst_q      <= 1'b1;
      dmem_rst_q      <= 1'b1;
      regfile_rst_q   <= 1'b1;
      proc_rst_q      <= 1'b1;
      seq_done_q      <= 1'b0;
      release_count_q <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      prev_lvl_q      <= prev_lvl_d;
      imem_rst_q      <= imem_rst_d;
      dmem_rst_q      <= dmem_rst_d;
      regfile_rst_q   <= regfile_rst_d;
      proc_rst_q      <= proc_rst_d;
      seq_done_q      <= seq_done_d;
      release_count_q <= release_count_d;
    end
  end

  assign imem_rst      = imem_rst_q;
  assign dmem_rst      = dmem_rst_q;
  assign regfile_rst   = regfile_rst_q;
  assign proc_rst      = proc_rst_q;
  assign seq_done      = seq_done_q;
  assign release_count = release_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues each expected output change
// (edge number plus output vector); monitors pop and compare whenever outputs change.
module tb_reset_sequencer;

  logic       clock;
  logic       reset, soft_rst_req, proc_clk_level;
  logic       imem_rst, dmem_rst, regfile_rst, proc_rst, seq_done;
  logic [7:0] release_count;

  logic       reset2, soft2, lvl2;
  logic       imem2, dmem2, rf2, proc2, done2;
  logic [7:0] count2;

  reset_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .soft_rst_req   (soft_rst_req),
    .proc_clk_level (proc_clk_level),
    .imem_rst       (imem_rst),
    .dmem_rst       (dmem_rst),
    .regfile_rst    (regfile_rst),
    .proc_rst       (proc_rst),
    .seq_done       (seq_done),
    .release_count  (release_count)
  );

  reset_sequencer #(.HOLD_CYCLES(1), .STAGE_GAP(1)) dut2 (
    .clock          (clock),
    .reset          (reset2),
    .soft_rst_req   (soft2),
    .proc_clk_level (lvl2),
    .imem_rst       (imem2),
    .dmem_rst       (dmem2),
    .regfile_rst    (rf2),
    .proc_rst       (proc2),
    .seq_done       (done2),
    .release_count  (count2)
  );

  typedef struct {
    int         cyc;
    logic [12:0] v;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  logic [12:0] prev1, prev2;
  bit          seen1 = 1'b0;
  bit          seen2 = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(string name, int acyc, logic [12:0] av, int ecyc, logic [12:0] ev);
    total++;
    if (acyc == ecyc && av === ev) passed++;
    else $display("FAIL %s: got edge %0d outs %b, want edge %0d outs %b", name, acyc, av, ecyc, ev);
  endfunction

  task automatic exp1(int e, logic [3:0] r, logic d, logic [7:0] c);
    q1.push_back('{cyc: e, v: {r, d, c}});
  endtask

  task automatic exp2(int e, logic [3:0] r, logic d, logic [7:0] c);
    q2.push_back('{cyc: e, v: {r, d, c}});
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Outputs are {imem, dmem, regfile, proc, seq_done, release_count}
  always @(negedge clock) begin
    logic [12:0] cur;
    exp_t        e;
    cur = {imem_rst, dmem_rst, regfile_rst, proc_rst, seq_done, release_count};
    if (!seen1 || cur !== prev1) begin
      seen1 = 1'b1;
      prev1 = cur;
      if (q1.size() == 0) begin
        total++;
        $display("FAIL dut1_unexpected: got edge %0d outs %b, want no change", cyc, cur);
      end else begin
        e = q1.pop_front();
        check("dut1_event", cyc, cur, e.cyc, e.v);
      end
    end
  end

  always @(negedge clock) begin
    logic [12:0] cur;
    exp_t        e;
    cur = {imem2, dmem2, rf2, proc2, done2, count2};
    if (!seen2 || cur !== prev2) begin
      seen2 = 1'b1;
      prev2 = cur;
      if (q2.size() == 0) begin
        total++;
        $display("FAIL dut2_unexpected: got edge %0d outs %b, want no change", cyc, cur);
      end else begin
        e = q2.pop_front();
        check("dut2_event", cyc, cur, e.cyc, e.v);
      end
    end
  end

  initial begin
    int base;
    int cb, ca;
    reset = 1'b1;  soft_rst_req = 1'b0;  proc_clk_level = 1'b0;
    reset2 = 1'b1; soft2 = 1'b0;         lvl2 = 1'b0;

    // reset state seen right after the first edge
    exp1(1, 4'b1111, 1'b0, 8'd0);
    exp2(1, 4'b1111, 1'b0, 8'd0);
    tick(3);

    // power-on sequence, proc clock period 4 (2 high, 2 low), reset released at edge 4
    base = cyc;
    exp1(base + 7,  4'b0011, 1'b0, 8'd0);
    exp1(base + 9,  4'b0001, 1'b0, 8'd0);
    exp1(base + 11, 4'b0000, 1'b1, 8'd1);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      proc_clk_level = ((i % 4) < 2);
      tick(1);
    end

    // restart, then proc clock parked low far beyond the hold time
    proc_clk_level = 1'b0;
    soft_rst_req = 1'b1;
    exp1(cyc + 1, 4'b1111, 1'b0, 8'd1);
    tick(1);
    soft_rst_req = 1'b0;
    tick(110);
    base = cyc;
    exp1(base + 2, 4'b0011, 1'b0, 8'd1);
    exp1(base + 4, 4'b0001, 1'b0, 8'd1);
    exp1(base + 6, 4'b0000, 1'b1, 8'd2);
    proc_clk_level = 1'b1; tick(1);
    proc_clk_level = 1'b0; tick(1);
    tick(4);

    // restart held 3 cycles (counter frozen), then pulse restart while in REL_RF
    base = cyc;
    exp1(base + 1,  4'b1111, 1'b0, 8'd2);
    exp1(base + 9,  4'b0011, 1'b0, 8'd2);
    exp1(base + 11, 4'b0001, 1'b0, 8'd2);
    exp1(base + 12, 4'b1111, 1'b0, 8'd2);
    exp1(base + 18, 4'b0011, 1'b0, 8'd2);
    exp1(base + 20, 4'b0001, 1'b0, 8'd2);
    exp1(base + 22, 4'b0000, 1'b1, 8'd3);
    soft_rst_req = 1'b1; tick(3);
    soft_rst_req = 1'b0; tick(2);
    proc_clk_level = 1'b1; tick(1);
    proc_clk_level = 1'b0; tick(1);
    proc_clk_level = 1'b1; tick(1);
    proc_clk_level = 1'b0; tick(1);
    tick(2);
    soft_rst_req = 1'b1; tick(1);
    soft_rst_req = 1'b0; tick(4);
    proc_clk_level = 1'b1; tick(1);
    proc_clk_level = 1'b0; tick(1);
    tick(4);

    // reset (with restart also asserted) in RUN after 3 sequences, then restart coinciding with a fall
    base = cyc;
    exp1(base + 1,  4'b1111, 1'b0, 8'd0);
    exp1(base + 13, 4'b0011, 1'b0, 8'd0);
    exp1(base + 15, 4'b0001, 1'b0, 8'd0);
    exp1(base + 17, 4'b0000, 1'b1, 8'd1);
    reset = 1'b1; soft_rst_req = 1'b1; tick(1);
    reset = 1'b0; soft_rst_req = 1'b0; tick(4);
    proc_clk_level = 1'b1; tick(1);
    proc_clk_level = 1'b0; soft_rst_req = 1'b1; tick(1);
    soft_rst_req = 1'b0; tick(2);
    proc_clk_level = 1'b1; tick(1);
    proc_clk_level = 1'b0; tick(1);
    proc_clk_level = 1'b1; tick(1);
    proc_clk_level = 1'b0; tick(1);
    tick(4);

    // 256 restart+complete loops on the fast instance; count saturates at 255
    reset2 = 1'b0;
    for (int l = 0; l < 256; l++) begin
      base = cyc;
      cb = (l > 255) ? 255 : l;
      ca = (l + 1 > 255) ? 255 : l + 1;
      if (l > 0) exp2(base + 1, 4'b1111, 1'b0, 8'(cb));
      exp2(base + 3, 4'b0011, 1'b0, 8'(cb));
      exp2(base + 4, 4'b0001, 1'b0, 8'(cb));
      exp2(base + 5, 4'b0000, 1'b1, 8'(ca));
      soft2 = 1'b1; tick(1);
      soft2 = 1'b0; lvl2 = 1'b1; tick(1);
      lvl2 = 1'b0; tick(1);
      tick(2);
    end
    tick(5);

    total++;
    if (q1.size() == 0) passed++;
    else $display("FAIL dut1_missing: got %0d events outstanding, want 0", q1.size());
    total++;
    if (q2.size() == 0) passed++;
    else $display("FAIL dut2_missing: got %0d events outstanding, want 0", q2.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: clock cycles all resets stay asserted after reset release (legal range 1..255).
REQ-002 SHALL have parameter STAGE_GAP, default 2: clock cycles between successive reset-release stages (legal range 1..255).
REQ-003 SHALL have port clock, input, 1: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: one clock; reset is synchronous and active-high.
REQ-005 SHALL have port soft_rst_req, input, 1: synchronous request to restart the reset sequence.
REQ-006 SHALL have port proc_clk_level, input, 1: processor clock level, sampled in the clock domain.
REQ-007 SHALL have port imem_rst, output, 1: instruction-memory reset, active-high.
REQ-008 SHALL have port dmem_rst, output, 1: data-memory reset, active-high.
REQ-009 SHALL have port regfile_rst, output, 1: register-file reset, active-high.
REQ-010 SHALL have port proc_rst, output, 1: processor reset, active-high.
REQ-011 SHALL have port seq_done, output, 1: high when every reset is released.
REQ-012 SHALL have port release_count, output, 8: number of completed sequences, saturating.

Function
REQ-013 SHALL implement FSM states HOLD, WAIT_EDGE, REL_MEM, REL_RF, RUN; every output is registered.
REQ-014 SHALL keep an 8-bit stage counter and a 1-bit prev_lvl register; prev_lvl samples proc_clk_level on every edge.
REQ-015 SHALL detect a falling edge as prev_lvl=1 and proc_clk_level=0 in the same cycle.
REQ-016 HOLD: SHALL increment the counter each edge; on the edge where counter = HOLD_CYCLES-1, go to WAIT_EDGE and clear the counter.
REQ-017 WAIT_EDGE: SHALL wait with no timeout; on the edge where a falling edge is detected, go to REL_MEM with imem_rst=0 and dmem_rst=0 (both in the same cycle) and clear the counter.
REQ-018 REL_MEM: on the edge where counter = STAGE_GAP-1, SHALL go to REL_RF with regfile_rst=0 and clear the counter.
REQ-019 REL_RF: on the edge where counter = STAGE_GAP-1, SHALL go to RUN with proc_rst=0 and seq_done=1, and increment release_count.
REQ-020 Release order SHALL be fixed: memories, then register file, then processor; a later reset never deasserts before an earlier one.
REQ-021 RUN: SHALL hold all outputs stable until reset or soft_rst_req.
REQ-022 soft_rst_req=1 in any state other than HOLD: on the next edge SHALL go to HOLD with all four resets=1, seq_done=0, and counter=0; release_count is kept.
REQ-023 soft_rst_req=1 in HOLD: SHALL hold the counter at 0 while it stays asserted.
REQ-024 If soft_rst_req and a falling edge coincide in WAIT_EDGE, soft_rst_req SHALL win: the state stays or returns to HOLD and no reset releases.
REQ-025 release_count SHALL saturate at 255 and never wrap.

Reset
REQ-026 With reset=1 on an edge, SHALL set state=HOLD, counter=0, prev_lvl=0, all four resets=1, seq_done=0, release_count=0.
REQ-027 reset SHALL override soft_rst_req and all FSM activity, including mid-sequence.

Verification
REQ-028 Defaults; reset high 3 cycles then low at edge E0; proc_clk_level period 4 (2 high, 2 low) -> all resets=1 through E4; mem resets drop on the first detected falling edge after E4; regfile_rst drops 2 edges later; proc_rst and seq_done rise 2 edges after that; release_count=1.
REQ-029 proc_clk_level held 0 after HOLD -> sequencer stays in WAIT_EDGE, all resets=1, for 100 cycles; first 1->0 transition then starts the release.
REQ-030 soft_rst_req pulsed 1 cycle in REL_RF -> next edge all resets=1, seq_done=0; full sequence repeats; release_count ends at 1.
REQ-031 reset asserted in RUN after 3 completed sequences -> next edge all resets=1, release_count=0.
REQ-032 soft_rst_req and falling edge coincide in WAIT_EDGE -> no reset deasserts; HOLD restarts from counter 0.
REQ-033 256 soft-restart-plus-complete loops with HOLD_CYCLES=1, STAGE_GAP=1 -> release_count=255 after loop 255 and stays 255.
